timer_array: RTL and testbench
==============================

# timer_array

Parametrised successor to the single CP0 count/compare timer: one free-running prescaled counter with `NUM_CH` independent compare channels. Each channel has one-shot or periodic mode and a sticky overrun flag. Each channel raises a level interrupt request held until acknowledged. It sits beside `stage_mem` and drives a contiguous slice of the CPU `int_req` bus; the matching `int_ack` bits come back from the exception logic.

## Interface
- `NUM_CH`, default 4: number of compare channels (1..8).
- `WIDTH`, default 32: counter, compare and period width.
- `PS_WIDTH`, default 8: prescaler width.
- `CH_BITS`, default 2: channel-index width; must satisfy 2^`CH_BITS` ≥ `NUM_CH`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `prescale`  in  `PS_WIDTH`  count advances every `prescale`+1 cycles.
- `cfg_we`  in  1  configuration write strobe, one cycle.
- `cfg_ch`  in  `CH_BITS`  target channel.
- `cfg_field`  in  2  0 = compare, 1 = period, 2 = ctrl, 3 = global count.
  - For field 3, `cfg_ch` is ignored.
- `cfg_wdata`  in  `WIDTH`  write data.
  - For ctrl writes: bit0 = enable, bit1 = periodic, bit2 = clear overrun.
- `count`  out  `WIDTH`  current counter value.
- `int_req`  out  `NUM_CH`  per-channel pending interrupt, level.
- `int_ack`  in  `NUM_CH`  per-channel acknowledge, one-cycle pulse.
- `overrun`  out  `NUM_CH`  sticky: a match occurred while the channel was already pending.

## Operation
- Prescaler `ps_cnt`:
  - `tick` = (`ps_cnt` ≥ `prescale`).
  - On `tick`, `ps_cnt` ← 0; otherwise `ps_cnt` ← `ps_cnt`+1.
  - Using ≥ means a mid-run decrease of `prescale` ticks on the next cycle; there is no wrap hazard.
- Counter update, in priority order:
  - On a count write (`cfg_we` and field 3): `count` ← `cfg_wdata`, and `ps_cnt` ← 0.
  - Else on `tick`: `count` ← `count`+1, wrapping mod 2^`WIDTH`.
  - Else: `count` holds.
- Match:
  - `count_nxt` is the value `count` takes at this edge.
  - Channel i matches when it is enabled, `count_nxt` == `compare[i]`, and `count_nxt` ≠ `count` (the counter actually changed).
  - A count write that lands exactly on `compare[i]` counts as a match.
- On a match of channel i:
  - `pending[i]` ← 1. If `pending[i]` was already 1 and no ack arrives this cycle, `overrun[i]` ← 1.
  - Periodic mode: `compare[i]` ← `compare[i]` + `period[i]`, mod 2^`WIDTH`. A period of 0 re-arms on the same value, i.e. the channel fires once per full counter wrap.
  - One-shot mode: `enable[i]` ← 0.
- Acknowledge: `int_ack[i]` clears `pending[i]`.
- Same-edge conflicts:
  - Ack and match together: the match wins, `pending` stays 1, and `overrun` is not set.
  - A config write of compare, or of ctrl enable, in the same cycle as a match: the write value wins for that register, and the match's pending/overrun effects are still applied.
  - Ctrl write with bit2 = 1: clears `overrun[i]`. Bit2 reads as 0 and is not stored.
- Disabling a channel does not clear `pending`; software must still ack it.
- `int_req` = `pending`; `overrun` = overrun register. Both are direct register outputs with no combinational path from inputs.

## Timing
- Reset values:
  - `count`=0, `ps_cnt`=0.
  - All `compare`, `period`, `enable`, `periodic`, `pending`, `overrun` = 0.
  - Therefore `int_req`=0 and `overrun`=0.
- A write becomes visible at the next edge; a write and its effect on matching take zero extra cycles.
- `int_req[i]` rises on the same edge at which `count` becomes equal to `compare[i]`.
- `int_req[i]` falls on the edge after `int_ack[i]` is sampled high.
- Reset asserted mid-operation returns all state to the reset values immediately; a pending interrupt is lost.
- Throughput:
  - With `prescale`=0, every cycle is a tick.
  - With `prescale`=P, `count` changes every P+1 cycles.

## Structure
- Shared header `timer_def.vh` holds:
  - the `TMR_FIELD_*` codes (COMPARE, PERIOD, CTRL, COUNT);
  - the `TMR_CTRL_*` bit positions (ENABLE, PERIODIC, CLR_OVR);
  - the base index of the timer slice inside the `INT_*` map.
- Sub-module `timer_channel` is instantiated `NUM_CH` times via generate. It holds compare, period, ctrl, pending, and overrun.
  - Inputs: `count`, `count_nxt`, `count_chg`, the write strobes decoded for this channel, `cfg_wdata`, and its `int_ack` bit.
  - Outputs: its `int_req` bit and its `overrun` bit.
- The top level keeps the prescaler, the counter and the write decode.

## Test plan
- Reset with `prescale`=0: `count` is 0 and `int_req` is 0. After 10 cycles, `count`=10.
- ch0 one-shot, compare=5, `prescale`=0:
  - `int_req[0]` rises on the edge where `count` becomes 5, and ch0's enable clears.
  - Ack at cycle 8 drops `int_req[0]` at the next edge.
  - There is no refire when `count` wraps past 5 later.
- ch1 periodic, compare=4, period=3, never acked:
  - `pending` is set at count 4; `overrun[1]`=1 at count 7; the next match is at count 10.
  - A ctrl write with bit2 = 1 clears `overrun[1]`.
- Ack at the match edge: ch2 periodic, compare=6, ack pulsed in the cycle when `count` goes 8→9 with period 3 (compare is 9 at that point) → `int_req[2]` stays 1 and `overrun[2]` stays 0.
- `prescale`=3: `count` advances every 4 cycles. Writing count=0xFFFFFFFF with ch3 compare=0 → ch3 fires 4 cycles later, when `count` wraps to 0.
- Count write equal to compare: ch0 enabled, compare=0x100, write count=0x100 → `int_req[0]`=1 at that edge.

Source files
------------

// File: rtl/timer_array_pkg.sv
// Shared definitions for the compare-timer array: config field codes,
// ctrl bit positions and the position of the timer slice in the CPU
// interrupt map.
package timer_array_pkg;

  // Configuration field selector carried on cfg_field.
  typedef enum logic [1:0] {
    TMR_FIELD_COMPARE = 2'd0,
    TMR_FIELD_PERIOD  = 2'd1,
    TMR_FIELD_CTRL    = 2'd2,
    TMR_FIELD_COUNT   = 2'd3
  } tmr_field_e;

  // Bit positions inside a ctrl write.
  localparam int TMR_CTRL_ENABLE   = 0;
  localparam int TMR_CTRL_PERIODIC = 1;
  localparam int TMR_CTRL_CLR_OVR  = 2;

  // First int_req bit driven by this block inside the CPU interrupt map.
  localparam int INT_TIMER_BASE = 2;

endpackage

// File: rtl/timer_channel.sv
// One compare channel: compare/period/ctrl registers plus the pending
// interrupt and sticky overrun flags. Matching is evaluated against the
// counter value being loaded at this edge, so the request rises together
// with the counter reaching the compare value.
module timer_channel
  import timer_array_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_nxt,
  input  logic             count_chg,
  input  logic             wr_compare,
  input  logic             wr_period,
  input  logic             wr_ctrl,
  input  logic [WIDTH-1:0] cfg_wdata,
  input  logic             int_ack,
  output logic             int_req,
  output logic             overrun
);

  logic [WIDTH-1:0] compare_q, compare_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             enable_q, enable_d;
  logic             periodic_q, periodic_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic             match;

  // A match needs the counter to have actually moved onto the compare value.
  assign match = enable_q && count_chg && (count_nxt == compare_q);

  // Next-state: match effects first, then config writes override registers.
  always_comb begin
    compare_d  = compare_q;
    period_d   = period_q;
    enable_d   = enable_q;
    periodic_d = periodic_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;

    if (int_ack) begin
      pending_d = 1'b0;
    end

    if (match) begin
      // Match beats a same-cycle ack; an ack in that cycle also hides the
      // overrun because software has just serviced the previous event.
      pending_d = 1'b1;
      if (pending_q && !int_ack) begin
        overrun_d = 1'b1;
      end
      if (periodic_q) begin
        compare_d = compare_q + period_q;
      end else begin
        enable_d = 1'b0;
      end
    end

    if (wr_compare) begin
      compare_d = cfg_wdata;
    end
    if (wr_period) begin
      period_d = cfg_wdata;
    end
    if (wr_ctrl) begin
      enable_d   = cfg_wdata[TMR_CTRL_ENABLE];
      periodic_d = cfg_wdata[TMR_CTRL_PERIODIC];
      if (cfg_wdata[TMR_CTRL_CLR_OVR]) begin
        overrun_d = 1'b0;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare_q  <= '0;
      period_q   <= '0;
      enable_q   <= 1'b0;
      periodic_q <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      compare_q  <= compare_d;
      period_q   <= period_d;
      enable_q   <= enable_d;
      periodic_q <= periodic_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
    end
  end

  assign int_req = pending_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/timer_array.sv
// Free-running prescaled counter shared by NUM_CH compare channels.
// The top keeps the prescaler, the counter and the config write decode;
// each channel owns its own compare state and interrupt flags.
module timer_array
  import timer_array_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 32,
  parameter int PS_WIDTH = 8,
  parameter int CH_BITS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PS_WIDTH-1:0] prescale,
  input  logic                cfg_we,
  input  logic [CH_BITS-1:0]  cfg_ch,
  input  logic [1:0]          cfg_field,
  input  logic [WIDTH-1:0]    cfg_wdata,
  output logic [WIDTH-1:0]    count,
  output logic [NUM_CH-1:0]   int_req,
  input  logic [NUM_CH-1:0]   int_ack,
  output logic [NUM_CH-1:0]   overrun
);

  logic [PS_WIDTH-1:0] ps_cnt_q, ps_cnt_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic                tick;
  logic                count_wr;
  logic                count_chg;
  tmr_field_e          field;

  assign field    = tmr_field_e'(cfg_field);
  // >= rather than == so lowering prescale mid-run ticks right away.
  assign tick     = (ps_cnt_q >= prescale);
  assign count_wr = cfg_we && (field == TMR_FIELD_COUNT);

  // Counter and prescaler next-state; a count write also restarts the prescaler.
  always_comb begin
    count_d  = count_q;
    ps_cnt_d = ps_cnt_q + PS_WIDTH'(1);
    if (count_wr) begin
      count_d  = cfg_wdata;
      ps_cnt_d = '0;
    end else if (tick) begin
      count_d  = count_q + WIDTH'(1);
      ps_cnt_d = '0;
    end
  end

  assign count_chg = (count_d != count_q);

  // Counter and prescaler registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      ps_cnt_q <= '0;
    end else begin
      count_q  <= count_d;
      ps_cnt_q <= ps_cnt_d;
    end
  end

  assign count = count_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic sel;
      assign sel = cfg_we && (cfg_ch == CH_BITS'(gi));

      timer_channel #(
        .WIDTH (WIDTH)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .count_nxt  (count_d),
        .count_chg  (count_chg),
        .wr_compare (sel && (field == TMR_FIELD_COMPARE)),
        .wr_period  (sel && (field == TMR_FIELD_PERIOD)),
        .wr_ctrl    (sel && (field == TMR_FIELD_CTRL)),
        .cfg_wdata  (cfg_wdata),
        .int_ack    (int_ack[gi]),
        .int_req    (int_req[gi]),
        .overrun    (overrun[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_timer_array.sv
// Directed bench for timer_array with a cycle-level behavioural model.
module tb_timer_array;

  localparam int NUM_CH   = 4;
  localparam int WIDTH    = 32;
  localparam int PS_WIDTH = 8;
  localparam int CH_BITS  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [PS_WIDTH-1:0] prescale;
  logic                cfg_we;
  logic [CH_BITS-1:0]  cfg_ch;
  logic [1:0]          cfg_field;
  logic [WIDTH-1:0]    cfg_wdata;
  logic [WIDTH-1:0]    count;
  logic [NUM_CH-1:0]   int_req;
  logic [NUM_CH-1:0]   int_ack;
  logic [NUM_CH-1:0]   overrun;

  timer_array #(
    .NUM_CH   (NUM_CH),
    .WIDTH    (WIDTH),
    .PS_WIDTH (PS_WIDTH),
    .CH_BITS  (CH_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prescale  (prescale),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_field (cfg_field),
    .cfg_wdata (cfg_wdata),
    .count     (count),
    .int_req   (int_req),
    .int_ack   (int_ack),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state.
  logic [WIDTH-1:0] m_count;
  int               m_ps;
  logic [WIDTH-1:0] m_cmp [NUM_CH];
  logic [WIDTH-1:0] m_per [NUM_CH];
  bit               m_en  [NUM_CH];
  bit               m_perd[NUM_CH];
  bit               m_pend[NUM_CH];
  bit               m_ovr [NUM_CH];

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_count = '0;
    m_ps    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_cmp[i] = '0; m_per[i] = '0; m_en[i] = 0;
      m_perd[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
    end
  endtask

  // Apply one clock edge of the specified behaviour to the model.
  task automatic model_update();
    logic [WIDTH-1:0] nxt;
    bit hit;
    if (cfg_we && cfg_field == 2'd3) begin
      nxt = cfg_wdata; m_ps = 0;
    end else if (m_ps >= int'(prescale)) begin
      nxt = m_count + 1; m_ps = 0;
    end else begin
      nxt = m_count; m_ps++;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      hit = m_en[i] && (nxt != m_count) && (nxt == m_cmp[i]);
      if (hit) begin
        if (m_pend[i] && !int_ack[i]) m_ovr[i] = 1;
        m_pend[i] = 1;
        if (m_perd[i]) m_cmp[i] = m_cmp[i] + m_per[i];
        else m_en[i] = 0;
      end else if (int_ack[i]) begin
        m_pend[i] = 0;
      end
      if (cfg_we && int'(cfg_ch) == i) begin
        case (cfg_field)
          2'd0: m_cmp[i] = cfg_wdata;
          2'd1: m_per[i] = cfg_wdata;
          2'd2: begin
            m_en[i]   = cfg_wdata[0];
            m_perd[i] = cfg_wdata[1];
            if (cfg_wdata[2]) m_ovr[i] = 0;
          end
          default: ;
        endcase
      end
    end
    m_count = nxt;
  endtask

  // Compare every visible output against the model.
  task automatic compare_all();
    logic [WIDTH-1:0] req_v, ovr_v;
    req_v = '0; ovr_v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_v[i] = m_pend[i];
      ovr_v[i] = m_ovr[i];
    end
    chk("model_count", count, m_count);
    chk("model_int_req", WIDTH'(int_req), req_v);
    chk("model_overrun", WIDTH'(overrun), ovr_v);
  endtask

  // One clock: inputs already driven; update model at the edge, check at negedge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_update();
    @(negedge clk);
    compare_all();
    cfg_we  = 1'b0;
    int_ack = '0;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(input int ch, input int field, input logic [WIDTH-1:0] data);
    cfg_we    = 1'b1;
    cfg_ch    = CH_BITS'(ch);
    cfg_field = 2'(field);
    cfg_wdata = data;
    step();
  endtask

  task automatic ack(input logic [NUM_CH-1:0] mask);
    int_ack = mask;
    step();
  endtask

  initial begin
    rst = 1'b1; prescale = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_field = '0; cfg_wdata = '0; int_ack = '0;
    model_reset();
    steps(2);
    rst = 1'b0;
    chk("reset_count", count, 32'd0);
    chk("reset_int_req", WIDTH'(int_req), 32'd0);
    steps(10);
    chk("count_after_10", count, 32'd10);

    // ch0 one-shot at 5
    wr(0, 0, 32'd5);
    wr(0, 2, 32'd1);
    wr(0, 3, 32'd0);
    steps(4);
    chk("ch0_before_match", WIDTH'(int_req), 32'd0);
    step();
    chk("ch0_match_count", count, 32'd5);
    chk("ch0_match_req", WIDTH'(int_req), 32'd1);
    steps(2);
    ack(4'b0001);
    chk("ch0_ack_drop", WIDTH'(int_req), 32'd0);
    wr(0, 3, 32'hFFFF_FFF0);
    steps(25);
    chk("ch0_no_refire_count", count, 32'd9);
    chk("ch0_no_refire_req", WIDTH'(int_req), 32'd0);

    // ch1 periodic 4,+3, not acked
    wr(1, 0, 32'd4);
    wr(1, 1, 32'd3);
    wr(1, 2, 32'd3);
    wr(0, 3, 32'd0);
    steps(4);
    chk("ch1_first_req", WIDTH'(int_req), 32'h2);
    chk("ch1_first_ovr", WIDTH'(overrun), 32'h0);
    steps(3);
    chk("ch1_ovr_at_7", WIDTH'(overrun), 32'h2);
    step();
    ack(4'b0010);
    chk("ch1_acked_at_9", WIDTH'(int_req), 32'h0);
    step();
    chk("ch1_refire_at_10", WIDTH'(int_req), 32'h2);
    wr(1, 2, 32'd7);
    chk("ch1_ovr_cleared", WIDTH'(overrun), 32'h0);
    wr(1, 2, 32'd0);
    ack(4'b0010);
    chk("ch1_disabled_acked", WIDTH'(int_req), 32'h0);

    // ch2 periodic 6,+3, ack lands on the match at 9
    wr(2, 0, 32'd6);
    wr(2, 1, 32'd3);
    wr(2, 2, 32'd3);
    wr(0, 3, 32'd0);
    steps(6);
    chk("ch2_req_at_6", WIDTH'(int_req), 32'h4);
    steps(2);
    ack(4'b0100);
    chk("ch2_ack_match_count", count, 32'd9);
    chk("ch2_ack_match_req", WIDTH'(int_req), 32'h4);
    chk("ch2_ack_match_ovr", WIDTH'(overrun), 32'h0);
    wr(2, 2, 32'd0);
    ack(4'b0100);

    // ch3 one-shot at 0 with prescale 3 across the wrap
    wr(3, 0, 32'd0);
    wr(3, 2, 32'd1);
    prescale = 8'd3;
    wr(0, 3, 32'hFFFF_FFFF);
    steps(3);
    chk("ps3_hold_count", count, 32'hFFFF_FFFF);
    chk("ps3_hold_req", WIDTH'(int_req), 32'h0);
    step();
    chk("ps3_wrap_count", count, 32'd0);
    chk("ps3_wrap_req", WIDTH'(int_req), 32'h8);
    ack(4'b1000);
    steps(3);
    chk("ps3_next_tick", count, 32'd1);

    // count write landing on compare
    prescale = 8'd0;
    wr(0, 0, 32'h100);
    wr(0, 2, 32'd1);
    wr(0, 3, 32'h100);
    chk("cw_match_req", WIDTH'(int_req), 32'h1);
    steps(2);

    // asynchronous reset mid-operation
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_count", count, 32'd0);
    chk("async_rst_req", WIDTH'(int_req), 32'h0);
    step();
    rst = 1'b0;
    steps(3);
    chk("post_rst_count", count, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
